combo_entry: RTL
================

COMBO_ENTRY -- requirements
Module: combo_entry

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles required before a button level is accepted.
REQ-002 clk  input  1  single clock; all logic updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 en  input  1  entry enable from the lock; low clears and idles the block.
REQ-005 btn_inc  input  1  raw asynchronous button; increments the selected digit.
REQ-006 btn_next  input  1  raw asynchronous button; toggles the selected digit.
REQ-007 btn_submit  input  1  raw asynchronous button; requests submission.
REQ-008 attempt_ready  input  1  lock accepts the attempt this cycle.
REQ-009 attempt_valid  output  1  attempt offered to the lock.
REQ-010 passcode_attempt  output  8  {hi_digit, lo_digit}.
REQ-011 sel_hi  output  1  1 = high digit selected for editing.
REQ-012 led1, led0  output  7 each  active-low 7-seg, bit order {g,f,e,d,c,b,a}; led1 = hi_digit, led0 = lo_digit.

Function
REQ-013 Each button passes through a 2-flop synchronizer and then a debouncer; the debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-014 A press event is a one-cycle pulse on a debounced 0->1 transition; holding a button yields exactly one event.
REQ-015 FSM states: IDLE, EDIT, SEND.
REQ-016 IDLE: digits = 0, sel_hi = 0, attempt_valid = 0; en = 1 -> EDIT next cycle.
REQ-017 EDIT: inc event adds 1 mod 16 to the selected digit (F wraps to 0, other digit unchanged); next event toggles sel_hi; submit event -> SEND.
REQ-018 Simultaneous events in EDIT: submit has priority and inc/next are dropped; when inc and next coincide, inc applies to the pre-toggle digit and sel_hi then toggles.
REQ-019 SEND: attempt_valid = 1; passcode_attempt holds stable; all button events are ignored.
REQ-020 Handshake: transfer occurs on a cycle with attempt_valid & attempt_ready; next cycle -> EDIT, digits = 0, sel_hi = 0, attempt_valid = 0.
REQ-021 attempt_valid does not depend combinationally on attempt_ready; attempt_ready is ignored outside SEND.
REQ-022 en = 0 in any state -> IDLE next cycle, overriding all events and any pending transfer (valid drops, no transfer counted).
REQ-023 All outputs are registered; led0/led1 reflect the digit registers with one cycle of latency.
REQ-024 Hex glyphs: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10, A=0x08, b=0x03, C=0x46, d=0x21, E=0x06, F=0x0E.

Reset
REQ-025 While rst = 1: state = IDLE, digits = 0, sel_hi = 0, attempt_valid = 0, passcode_attempt = 0x00, led1 = led0 = 0x40, debounced levels = 0, debounce counters = 0.
REQ-026 rst asserted mid-SEND drops attempt_valid the following cycle with no transfer; a button held through reset release produces no event until it is released and pressed again.

Structure
REQ-027 A shared package holds the FSM state enum and the 16-entry hex-to-7-seg constant table, so the lock display logic reuses the same table.
REQ-028 One sub-module, btn_debounce (synchronizer + debouncer + rising-edge pulse, parameter DEBOUNCE_CYCLES), is instantiated three times.

Verification
REQ-029 Reset, en = 1, press next once, press inc 4 times, press next, press inc 9 times, press submit -> attempt_valid = 1, passcode_attempt = 0x49, led1 = 0x19, led0 = 0x10.
REQ-030 SEND with attempt_ready = 0 for 10 cycles while inc is pressed -> passcode_attempt stays 0x49; ready = 1 -> valid = 0 next cycle, digits = 0x00.
REQ-031 Input bouncing (toggling every 3 cycles for 40 cycles, DEBOUNCE_CYCLES = 16) and then held high -> exactly one inc event; a 10-cycle glitch -> no event.
REQ-032 Press inc 17 times on lo_digit -> lo_digit = 1, wrap with no carry, hi_digit = 0.
REQ-033 Drop en during SEND -> IDLE, valid = 0, leds = 0x40/0x40, no transfer; assert rst mid-SEND -> same outputs.
REQ-034 inc and submit debounced in the same cycle -> SEND with passcode_attempt unchanged from before the press.

Source files
------------

// File: rtl/combo_entry_pkg.sv
// Shared definitions for the combination-entry block and the lock display:
// FSM state encoding and the hex-to-7-segment glyph table.
package combo_entry_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EDIT = 2'd1,
        ST_SEND = 2'd2
    } state_e;

    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    // Entry 0 is the least significant element of the packed array, so the list
    // below runs from glyph F down to glyph 0.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    localparam logic [6:0] SEG_BLANK_ZERO = 7'h40;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] digit);
        return SEG_TABLE[digit];
    endfunction

endpackage

// File: rtl/combo_entry_btn_debounce.sv
// Button conditioning: 2-flop synchronizer, counting debouncer and a
// one-cycle press pulse on each accepted 0->1 transition of the debounced level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          armed_q, armed_d;
    logic [CW-1:0] arm_cnt_q, arm_cnt_d;
    logic          press_q;
    logic          flip;

    // A flip happens on the cycle the synchronized input has disagreed with the
    // debounced level for the full window.
    assign flip = (sync2_q != level_q) && (cnt_q == CNT_LAST);

    // Two-flop synchronizer for the raw asynchronous button.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: count consecutive disagreeing cycles, restart on any agreement.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (flip) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Arming: after reset a press only counts once the button has been seen
    // released for a full debounce window, so a button held through reset
    // release never produces an event until it is let go and pressed again.
    always_comb begin
        armed_d   = armed_q;
        arm_cnt_d = arm_cnt_q;
        if (!armed_q) begin
            if (sync2_q) begin
                arm_cnt_d = '0;
            end else if (arm_cnt_q == CNT_LAST) begin
                armed_d = 1'b1;
            end else begin
                arm_cnt_d = arm_cnt_q + 1'b1;
            end
        end
    end

    // Debouncer, arming and press-pulse state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q   <= 1'b0;
            cnt_q     <= '0;
            armed_q   <= 1'b0;
            arm_cnt_q <= '0;
            press_q   <= 1'b0;
        end else begin
            level_q   <= level_d;
            cnt_q     <= cnt_d;
            armed_q   <= armed_d;
            arm_cnt_q <= arm_cnt_d;
            press_q   <= flip && sync2_q && armed_q;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/combo_entry.sv
// Two-digit hex combination entry: three debounced buttons edit a {hi,lo}
// digit pair, submit offers it to the lock over a valid/ready handshake.
module combo_entry
    import combo_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       btn_inc,
    input  logic       btn_next,
    input  logic       btn_submit,
    input  logic       attempt_ready,
    output logic       attempt_valid,
    output logic [7:0] passcode_attempt,
    output logic       sel_hi,
    output logic [6:0] led1,
    output logic [6:0] led0
);

    logic inc_evt, next_evt, submit_evt;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_inc),
        .press_o (inc_evt)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_next),
        .press_o (next_evt)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_submit (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_submit),
        .press_o (submit_evt)
    );

    state_e     state_q;
    logic [3:0] hi_q, lo_q;
    logic       sel_hi_q;
    logic       valid_q;
    logic [6:0] led1_q, led0_q;

    // Entry FSM with digit registers; valid is high exactly while in SEND, so
    // it never depends on attempt_ready combinationally. The displays trail the
    // digit registers by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            hi_q     <= 4'h0;
            lo_q     <= 4'h0;
            sel_hi_q <= 1'b0;
            valid_q  <= 1'b0;
            led1_q   <= SEG_BLANK_ZERO;
            led0_q   <= SEG_BLANK_ZERO;
        end else begin
            led1_q <= hex_to_seg(hi_q);
            led0_q <= hex_to_seg(lo_q);
            if (!en) begin
                // Disable wins over every event and any offered attempt.
                state_q  <= ST_IDLE;
                hi_q     <= 4'h0;
                lo_q     <= 4'h0;
                sel_hi_q <= 1'b0;
                valid_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        hi_q     <= 4'h0;
                        lo_q     <= 4'h0;
                        sel_hi_q <= 1'b0;
                        valid_q  <= 1'b0;
                        state_q  <= ST_EDIT;
                    end
                    ST_EDIT: begin
                        if (submit_evt) begin
                            // Submit drops any coincident inc/next.
                            state_q <= ST_SEND;
                            valid_q <= 1'b1;
                        end else begin
                            // Inc uses the pre-toggle selection when next coincides.
                            if (inc_evt) begin
                                if (sel_hi_q) hi_q <= hi_q + 4'd1;
                                else          lo_q <= lo_q + 4'd1;
                            end
                            if (next_evt) begin
                                sel_hi_q <= ~sel_hi_q;
                            end
                        end
                    end
                    ST_SEND: begin
                        if (valid_q && attempt_ready) begin
                            state_q  <= ST_EDIT;
                            hi_q     <= 4'h0;
                            lo_q     <= 4'h0;
                            sel_hi_q <= 1'b0;
                            valid_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign attempt_valid    = valid_q;
    assign passcode_attempt = {hi_q, lo_q};
    assign sel_hi           = sel_hi_q;
    assign led1             = led1_q;
    assign led0             = led0_q;

endmodule
